// File: rtl/matrix_calculator_pio_pkg.sv
// Shared definitions for the matrix calculator PIO master: FSM state encoding
// and default bus geometry / stall-timeout constants.
package matrix_calculator_pio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  // Wide enough for the largest legal TIMEOUT (65535).
  localparam int STALL_W = 16;

endpackage

// File: rtl/matrix_calculator_pio_master_if.sv
// Command/response handshake plus Avalon-MM PIO-style bus, bundled so the
// master and its environment share one signal set.
interface matrix_calculator_pio_master_if
  import matrix_calculator_pio_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
  );

endinterface

// File: rtl/matrix_calculator_pio_master.sv
// Single-outstanding command master that turns cmd/rsp handshakes into
// Avalon-MM PIO accesses, with waitrequest stall timeout and fixed read latency.
module matrix_calculator_pio_master
  import matrix_calculator_pio_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = DEF_TIMEOUT
)(
  input  logic                           clk,
  input  logic                           reset,
  matrix_calculator_pio_master_if.master io_bus
);

  localparam logic [STALL_W-1:0] TIMEOUT_LAST = STALL_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [STALL_W-1:0] r_stall;
  logic               r_is_write;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_error;
  logic [ADDR_W-1:0]  r_avm_address;
  logic               r_avm_chipselect;
  logic               r_avm_write_n;
  logic               r_avm_read_n;
  logic [DATA_W-1:0]  r_avm_writedata;

  // Strobes are set on the transition into ACCESS and cleared on the way out,
  // so they are high exactly for the ACCESS cycles and never on the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_stall          <= '0;
      r_is_write       <= 1'b0;
      r_cmd_ready      <= 1'b1;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= '0;
      r_rsp_error      <= 1'b0;
      r_avm_address    <= '0;
      r_avm_chipselect <= 1'b0;
      r_avm_write_n    <= 1'b1;
      r_avm_read_n     <= 1'b1;
      r_avm_writedata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.cmd_valid) begin
            r_is_write       <= io_bus.cmd_write;
            r_avm_address    <= io_bus.cmd_address;
            r_avm_writedata  <= io_bus.cmd_wdata;
            r_avm_chipselect <= 1'b1;
            r_avm_write_n    <= ~io_bus.cmd_write;
            r_avm_read_n     <= io_bus.cmd_write;
            r_stall          <= '0;
            r_cmd_ready      <= 1'b0;
            r_state          <= ACCESS;
          end
        end

        ACCESS: begin
          if (!io_bus.avm_waitrequest) begin
            r_avm_chipselect <= 1'b0;
            r_avm_write_n    <= 1'b1;
            r_avm_read_n     <= 1'b1;
            if (r_is_write) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_error <= 1'b0;
              r_state     <= RESP;
            end else if (READ_LATENCY == 0) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= io_bus.avm_readdata;
              r_rsp_error <= 1'b0;
              r_state     <= RESP;
            end else begin
              r_state <= WAIT_DATA;
            end
          end else begin
            r_stall <= r_stall + STALL_W'(1);
            // The slave has stalled for TIMEOUT cycles: abandon the access.
            if (r_stall == TIMEOUT_LAST) begin
              r_avm_chipselect <= 1'b0;
              r_avm_write_n    <= 1'b1;
              r_avm_read_n     <= 1'b1;
              r_rsp_valid      <= 1'b1;
              r_rsp_rdata      <= '0;
              r_rsp_error      <= 1'b1;
              r_state          <= RESP;
            end
          end
        end

        WAIT_DATA: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= io_bus.avm_readdata;
          r_rsp_error <= 1'b0;
          r_state     <= RESP;
        end

        RESP: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.cmd_ready      = r_cmd_ready;
  assign io_bus.rsp_valid      = r_rsp_valid;
  assign io_bus.rsp_rdata      = r_rsp_rdata;
  assign io_bus.rsp_error      = r_rsp_error;
  assign io_bus.avm_address    = r_avm_address;
  assign io_bus.avm_chipselect = r_avm_chipselect;
  assign io_bus.avm_write_n    = r_avm_write_n;
  assign io_bus.avm_read_n     = r_avm_read_n;
  assign io_bus.avm_writedata  = r_avm_writedata;

endmodule

// File: tb/tb_matrix_calculator_pio_master.sv
// Bench for matrix_calculator_pio_master: a one-register Avalon slave with
// programmable waitrequest stalls, a transaction-level reference model and directed sequences.
module tb_matrix_calculator_pio_master;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] slaveReg = 32'h0;
  int          stallReq = 0;
  int          stallCount = 0;

  int checkCount = 0;
  int failCount = 0;

  int acceptCount = 0;
  int rspCount = 0;
  int outstanding = 0;
  int maxOutstanding = 0;
  bit unstableSeen = 1'b0;
  bit strobeAtAccept = 1'b0;
  logic        prevCs = 1'b0;
  logic [1:0]  prevAddr = '0;
  logic [31:0] prevData = '0;
  logic        prevWrN = 1'b1;
  logic        prevRdN = 1'b1;

  logic [31:0] modelReg = 32'h0;

  matrix_calculator_pio_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  matrix_calculator_pio_master #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  // Slave: one register at address 0, registered read data, stalls for stallReq cycles.
  assign bus.avm_waitrequest = bus.avm_chipselect && (stallCount < stallReq);

  always @(posedge clk) begin
    if (!bus.avm_chipselect) stallCount <= 0;
    else if (bus.avm_waitrequest) stallCount <= stallCount + 1;
    if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest && bus.avm_address == 2'd0)
      slaveReg <= bus.avm_writedata;
    if (reset) bus.avm_readdata <= 32'h0;
    else if (bus.avm_chipselect && !bus.avm_read_n && !bus.avm_waitrequest)
      bus.avm_readdata <= (bus.avm_address == 2'd0) ? slaveReg : 32'h0;
  end

  always @(posedge clk) begin
    if (!reset && bus.cmd_valid && bus.cmd_ready) begin
      acceptCount = acceptCount + 1;
      if (bus.avm_chipselect || !bus.avm_write_n || !bus.avm_read_n) strobeAtAccept = 1'b1;
    end
    if (bus.rsp_valid) rspCount = rspCount + 1;
    if (reset) outstanding = 0;
    else outstanding = outstanding + int'(bus.cmd_valid && bus.cmd_ready) - int'(bus.rsp_valid);
    if (outstanding > maxOutstanding) maxOutstanding = outstanding;
    if (prevCs && bus.avm_chipselect &&
        (prevAddr !== bus.avm_address || prevData !== bus.avm_writedata ||
         prevWrN !== bus.avm_write_n || prevRdN !== bus.avm_read_n))
      unstableSeen = 1'b1;
    prevCs   = bus.avm_chipselect;
    prevAddr = bus.avm_address;
    prevData = bus.avm_writedata;
    prevWrN  = bus.avm_write_n;
    prevRdN  = bus.avm_read_n;
  end

  typedef struct {
    bit          write;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] expRdata;
    bit          expErr;
    int          expLat;
    int          expCs;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Transaction-level expectations: stall cycles add to latency unless the timeout wins.
  task automatic refModel(input bit write, input logic [1:0] addr, input logic [31:0] wdata,
                          input int stall, output logic [31:0] expRdata, output bit expErr,
                          output int expLat, output int expCs);
    bit timedOut = (stall >= TIMEOUT);
    expErr   = timedOut;
    expCs    = timedOut ? TIMEOUT : stall + 1;
    expLat   = timedOut ? TIMEOUT + 1 : (write ? 2 : 3) + stall;
    expRdata = (write || timedOut) ? 32'h0 : ((addr == 2'd0) ? modelReg : 32'h0);
    if (write && !timedOut && addr == 2'd0) modelReg = wdata;
  endtask

  task automatic applyStimulus(input bit write, input logic [1:0] addr, input logic [31:0] wdata,
                               input int stall, output logic [31:0] rdata, output logic err,
                               output int latency, output int csCycles, output logic firstWrN,
                               output logic firstRdN, output logic validAfter, output logic readyAfter);
    int guard = 0;
    stallReq = stall;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cmd_ready_before_cmd", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = write;
    bus.cmd_address = addr;
    bus.cmd_wdata   = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    latency  = 1;
    csCycles = 0;
    firstWrN = 1'b1;
    firstRdN = 1'b1;
    while (bus.rsp_valid !== 1'b1 && latency < 1000) begin
      if (bus.avm_chipselect === 1'b1) begin
        if (csCycles == 0) begin
          firstWrN = bus.avm_write_n;
          firstRdN = bus.avm_read_n;
        end
        csCycles++;
      end
      @(negedge clk);
      latency++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_error;
    @(negedge clk);
    validAfter = bus.rsp_valid;
    readyAfter = bus.cmd_ready;
    stallReq = 0;
  endtask

  task automatic runAndCheck(input string tag, input bit write, input logic [1:0] addr,
                             input logic [31:0] wdata, input int stall, input logic [31:0] expRdata,
                             input bit expErr, input int expLat, input int expCs);
    logic [31:0] rdata;
    logic err, wrN, rdN, vAfter, rAfter;
    int lat, cs;
    applyStimulus(write, addr, wdata, stall, rdata, err, lat, cs, wrN, rdN, vAfter, rAfter);
    checkOutput({tag, "_rdata"}, rdata, expRdata);
    checkOutput({tag, "_error"}, {31'b0, err}, {31'b0, expErr});
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_cs_cycles"}, 32'(cs), 32'(expCs));
    checkOutput({tag, "_write_n"}, {31'b0, wrN}, {31'b0, ~write});
    checkOutput({tag, "_read_n"}, {31'b0, rdN}, {31'b0, write});
    checkOutput({tag, "_valid_one_cycle"}, {31'b0, vAfter}, 32'd0);
    checkOutput({tag, "_ready_after"}, {31'b0, rAfter}, 32'd1);
  endtask

  initial begin
    logic [31:0] eRd;
    bit eErr;
    int eLat, eCs, accBefore, rspBefore, n, guard;
    logic readyNow;

    vecs[0] = '{1'b1, 2'd0, 32'h12345678, 0, 32'h0,        1'b0, 2, 1};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        0, 32'h12345678, 1'b0, 3, 1};
    vecs[2] = '{1'b0, 2'd1, 32'h0,        0, 32'h0,        1'b0, 3, 1};
    vecs[3] = '{1'b1, 2'd0, 32'hCAFEF00D, 3, 32'h0,        1'b0, 5, 4};
    vecs[4] = '{1'b0, 2'd0, 32'h0,        2, 32'hCAFEF00D, 1'b0, 5, 3};
    vecs[5] = '{1'b1, 2'd2, 32'hDEADBEEF, 0, 32'h0,        1'b0, 2, 1};
    vecs[6] = '{1'b0, 2'd0, 32'h0,        0, 32'hCAFEF00D, 1'b0, 3, 1};
    vecs[7] = '{1'b0, 2'd3, 32'h0,        1, 32'h0,        1'b0, 4, 2};

    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = 2'd0;
    bus.cmd_wdata   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("reset_rsp_error", {31'b0, bus.rsp_error}, 32'd0);
    checkOutput("reset_chipselect", {31'b0, bus.avm_chipselect}, 32'd0);
    checkOutput("reset_write_n", {31'b0, bus.avm_write_n}, 32'd1);
    checkOutput("reset_read_n", {31'b0, bus.avm_read_n}, 32'd1);
    checkOutput("reset_address", {30'b0, bus.avm_address}, 32'd0);
    checkOutput("reset_writedata", bus.avm_writedata, 32'h0);

    for (int i = 0; i < 8; i++) begin
      refModel(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].stall, eRd, eErr, eLat, eCs);
      runAndCheck($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                  vecs[i].stall, vecs[i].expRdata, vecs[i].expErr, vecs[i].expLat, vecs[i].expCs);
      if (i == 0) checkOutput("vec0_slave_reg", slaveReg, 32'h12345678);
    end

    for (int i = 0; i < 20; i++) begin
      bit w = 1'($urandom_range(0, 1));
      logic [1:0] a = 2'($urandom_range(0, 3));
      logic [31:0] d = $urandom;
      int s = int'($urandom_range(0, 4));
      refModel(w, a, d, s, eRd, eErr, eLat, eCs);
      runAndCheck($sformatf("rand%0d", i), w, a, d, s, eRd, eErr, eLat, eCs);
    end
    checkOutput("rand_slave_reg", slaveReg, modelReg);

    // Stuck waitrequest on a read: must abort with error and zero data.
    refModel(1'b0, 2'd0, 32'h0, 300, eRd, eErr, eLat, eCs);
    runAndCheck("timeout", 1'b0, 2'd0, 32'h0, 300, eRd, eErr, eLat, eCs);

    // Reset while the slave is stalling a write.
    stallReq = 10;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_address = 2'd0;
    bus.cmd_wdata   = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midaccess_cs", {31'b0, bus.avm_chipselect}, 32'd1);
    rspBefore = rspCount;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_cs", {31'b0, bus.avm_chipselect}, 32'd0);
    checkOutput("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    reset = 1'b0;
    stallReq = 0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_rsp", 32'(rspCount - rspBefore), 32'd0);
    checkOutput("abort_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    checkOutput("abort_slave_reg", slaveReg, modelReg);
    refModel(1'b1, 2'd0, 32'hA5A5F00F, 0, eRd, eErr, eLat, eCs);
    runAndCheck("post_abort", 1'b1, 2'd0, 32'hA5A5F00F, 0, eRd, eErr, eLat, eCs);
    checkOutput("post_abort_slave_reg", slaveReg, 32'hA5A5F00F);

    // cmd_valid held high across four back-to-back writes.
    accBefore = acceptCount;
    rspBefore = rspCount;
    n = 0;
    guard = 0;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_address = 2'd0;
    bus.cmd_wdata   = 32'hB0B00000;
    while (n < 4 && guard < 100) begin
      readyNow = bus.cmd_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (readyNow) begin
        n++;
        bus.cmd_wdata = 32'hB0B00000 + 32'(n);
      end
    end
    bus.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    modelReg = 32'hB0B00003;
    checkOutput("b2b_accepts", 32'(acceptCount - accBefore), 32'd4);
    checkOutput("b2b_responses", 32'(rspCount - rspBefore), 32'd4);
    checkOutput("b2b_max_outstanding", 32'(maxOutstanding), 32'd1);
    checkOutput("b2b_slave_reg", slaveReg, modelReg);

    checkOutput("bus_stable_in_access", {31'b0, unstableSeen}, 32'd0);
    checkOutput("no_strobe_at_accept", {31'b0, strobeAtAccept}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
